// File: rtl/fa4_bist.sv
// fa4_bist: built-in self-test engine for a 4-bit full adder.
// Sweeps all 512 {cin, b, a} combinations and holds each vector for SETTLE+1 cycles.
// Checks every adder result against a locally computed sum.
// Reports the error count and the index of the first failing vector.
module fa4_bist #(
    parameter int unsigned SETTLE = 1  // hold cycles before sampling, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic       cin_o,
    input  logic [3:0] sum_i,
    input  logic       carry_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_cnt,
    output logic [8:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
    localparam logic [8:0] VecLast    = 9'd511;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCheck,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] v_q, v_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] err_q, err_d;
    logic [8:0] ffvec_q, ffvec_d;
    logic       ffvalid_q, ffvalid_d;

    logic [4:0] ref_sum;
    logic       mismatch;

    // Reference result for the vector currently on the operand outputs
    always_comb begin
        ref_sum  = {1'b0, v_q[3:0]} + {1'b0, v_q[7:4]} + {4'b0, v_q[8]};
        mismatch = ({carry_i, sum_i} != ref_sum);
    end

    // Next-state logic: launch, settle, compare, advance
    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffvec_d   = ffvec_q;
        ffvalid_d = ffvalid_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    v_d       = '0;
                    cnt_d     = '0;
                    err_d     = '0;
                    ffvec_d   = '0;
                    ffvalid_d = 1'b0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    // 512 vectors at most, so 10 bits cannot overflow
                    err_d = err_q + 10'd1;
                    if (!ffvalid_q) begin
                        ffvec_d   = v_q;
                        ffvalid_d = 1'b1;
                    end
                end
                if (v_q == VecLast) begin
                    state_d = StDone;
                end else begin
                    v_d     = v_q + 9'd1;
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset aborts any sweep and discards results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            v_q       <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffvec_q   <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffvec_q   <= ffvec_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign a_o              = v_q[3:0];
    assign b_o              = v_q[7:4];
    assign cin_o            = v_q[8];
    assign busy             = (state_q == StWait) || (state_q == StCheck);
    assign done             = (state_q == StDone);
    assign pass             = done && (err_q == 10'd0);
    assign err_cnt          = err_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_fa4_bist.sv
// tb_fa4_bist: drives fa4_bist against a behavioural 4-bit adder with optional stuck-at faults.
// The expected counts come from a loop over all 512 vectors.
module tb_fa4_bist;

    localparam int unsigned SETTLE      = 1;
    localparam int          Hold        = SETTLE + 1;
    localparam int          SweepCycles = 512 * Hold;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a_o, b_o, sum_i;
    logic       cin_o, carry_i;
    logic       busy, done, pass;
    logic [9:0] err_cnt;
    logic [8:0] first_fail_vec;
    logic       first_fail_valid;

    int checks = 0;
    int errors = 0;

    // Fault injected on the adder output: bit 0..3 = sum, bit 4 = carry
    bit fault_en  = 1'b0;
    int fault_bit = 0;
    bit fault_val = 1'b0;

    always #5 clk = ~clk;

    fa4_bist #(.SETTLE(SETTLE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .a_o              (a_o),
        .b_o              (b_o),
        .cin_o            (cin_o),
        .sum_i            (sum_i),
        .carry_i          (carry_i),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_cnt          (err_cnt),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    function automatic logic [4:0] adder(input int a, input int b, input int c);
        int         r;
        logic [4:0] o;
        r = a + b + c;
        o = r[4:0];
        if (fault_en) o[fault_bit] = fault_val;
        return o;
    endfunction

    always_comb begin
        {carry_i, sum_i} = adder(int'(a_o), int'(b_o), int'(cin_o));
    end

    // Walk every vector in sweep order and count where the adder disagrees with arithmetic
    task automatic ref_model(output int cnt, output int first, output bit valid);
        int a, b, c;
        cnt = 0; first = 0; valid = 1'b0;
        for (int v = 0; v < 512; v++) begin
            a = v % 16;
            b = (v / 16) % 16;
            c = v / 256;
            if (int'(adder(a, b, c)) != a + b + c) begin
                if (!valid) begin
                    first = v;
                    valid = 1'b1;
                end
                cnt++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_vec"}, {23'd0, cin_o, b_o, a_o}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_pass"}, {31'd0, pass}, 0);
        check({tag, "_err"}, {22'd0, err_cnt}, 0);
        check({tag, "_ffvec"}, {23'd0, first_fail_vec}, 0);
        check({tag, "_ffvalid"}, {31'd0, first_fail_valid}, 0);
    endtask

    // One sweep from a start pulse; optionally poke start at cycle 500 or reset at rst_at
    task automatic sweep(input string tag, input bit poke500, input int rst_at);
        int ec, ff, exp_v;
        bit fv;
        ref_model(ec, ff, fv);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_e0_busy"}, {31'd0, busy}, 1);
        check({tag, "_e0_done"}, {31'd0, done}, 0);
        check({tag, "_e0_err"}, {22'd0, err_cnt}, 0);
        check({tag, "_e0_ffvalid"}, {31'd0, first_fail_valid}, 0);
        check({tag, "_e0_vec"}, {23'd0, cin_o, b_o, a_o}, 0);
        for (int n = 1; n <= SweepCycles; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_reset({tag, "_midrst"});
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            exp_v = (n < SweepCycles) ? n / Hold : 511;
            check({tag, "_vec"}, {23'd0, cin_o, b_o, a_o}, exp_v);
            check({tag, "_busy"}, {31'd0, busy}, (n < SweepCycles) ? 1 : 0);
            check({tag, "_done"}, {31'd0, done}, (n == SweepCycles) ? 1 : 0);
            if (poke500 && n == 500) start = 1'b1;
        end
        check({tag, "_err_cnt"}, {22'd0, err_cnt}, ec);
        check({tag, "_ffvalid"}, {31'd0, first_fail_valid}, fv ? 1 : 0);
        check({tag, "_ffvec"}, {23'd0, first_fail_vec}, ff);
        check({tag, "_pass"}, {31'd0, pass}, (ec == 0) ? 1 : 0);
    endtask

    initial begin
        // Reset with random inputs applied
        rst_n     = 1'b0;
        fault_en  = 1'b1;
        fault_bit = int'($urandom_range(0, 4));
        fault_val = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            @(posedge clk); #1;
            check_reset("rst");
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_busy", {31'd0, busy}, 0);
            check("idle_vec", {23'd0, cin_o, b_o, a_o}, 0);
        end

        // Good adder
        fault_en = 1'b0;
        sweep("good", 1'b0, -1);
        check("good_pass", {31'd0, pass}, 1);

        // sum[2] stuck-at-0
        fault_en  = 1'b1;
        fault_bit = 2;
        fault_val = 1'b0;
        sweep("sum2", 1'b0, -1);
        check("sum2_err_const", {22'd0, err_cnt}, 256);
        check("sum2_ff_const", {23'd0, first_fail_vec}, 4);

        // Restart from DONE, with a start poke mid-sweep that must be ignored
        sweep("restart", 1'b1, -1);
        check("restart_err_const", {22'd0, err_cnt}, 256);

        // carry stuck-at-0
        fault_bit = 4;
        fault_val = 1'b0;
        sweep("carry", 1'b0, -1);
        check("carry_err_const", {22'd0, err_cnt}, 256);
        check("carry_ff_const", {23'd0, first_fail_vec}, 31);

        // Reset mid-sweep, then a full sweep gives the uninterrupted counts
        sweep("abort", 1'b0, 300);
        sweep("after_abort", 1'b0, -1);
        check("after_abort_err_const", {22'd0, err_cnt}, 256);

        // Random single stuck-at faults
        for (int i = 0; i < 2; i++) begin
            fault_bit = int'($urandom_range(0, 4));
            fault_val = 1'($urandom_range(0, 1));
            sweep("rand", 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fa4_bist.md
# fa4_bist

Self-checking stimulus engine for the 4-bit full adder datapath: it drives the adder's `a`, `b`, `cin` inputs and samples its `sum` and `carry` outputs, sweeping all 512 input combinations and comparing each result against an internally computed reference. It is the synthesizable counterpart of the bench-side pattern driver. It sits beside an `FA_4bits` instance and reports pass/fail, error count and the first failing vector to a host or status register.

## Interface

- `SETTLE`, default 1: cycles each vector is held before sampling; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: launches a sweep when sampled high in IDLE or DONE.
- `a_o` output 4: adder operand a.
- `b_o` output 4: adder operand b.
- `cin_o` output 1: adder carry-in.
- `sum_i` input 4: adder sum, sampled in CHECK.
- `carry_i` input 1: adder carry-out, sampled in CHECK.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: high from sweep completion until the next accepted start or reset.
- `pass` output 1: high only when `done` is high and `err_cnt == 0`.
- `err_cnt` output 10: number of mismatching vectors, range 0..512.
- `first_fail_vec` output 9: vector index of the first mismatch in the current sweep.
- `first_fail_valid` output 1: high once `first_fail_vec` has been captured.

## Operation

- Vector index `v[8:0]` maps to the adder inputs as `a_o = v[3:0]`, `b_o = v[7:4]`, `cin_o = v[8]`. All three are registered straight from `v`.
- Reference result is the 5-bit value `{1'b0,a}+{1'b0,b}+cin`. The block compares `{carry_i,sum_i}` against it as a 5-bit equality.
- FSM states and transitions:
  - IDLE: on `start`, set `v=0`, clear `err_cnt`, `first_fail_*` and `done`, set `busy=1`, and go to WAIT.
  - WAIT: a settle counter counts 0..SETTLE-1. When the counter reaches SETTLE-1, go to CHECK.
  - CHECK: compare the adder result against the reference.
    - On mismatch, `err_cnt++`. If `first_fail_valid==0`, capture `v` into `first_fail_vec` and set `first_fail_valid`.
    - If `v==511`, go to DONE with `busy=0` and `done=1`.
    - Otherwise `v++` (operands update on the same edge) and return to WAIT.
  - DONE: hold all results. `start` behaves as it does in IDLE (restart).
- `start` is ignored while `busy` is high.
- `err_cnt` cannot overflow, because it saturates naturally at 512 with 10 bits.
- `v` never wraps within a sweep; the 511→0 transition occurs only through a new start.
- `pass` is combinational: `done & (err_cnt==0)`.
- Reset values: `a_o=0`, `b_o=0`, `cin_o=0`, `busy=0`, `done=0`, `err_cnt=0`, `first_fail_vec=0`, `first_fail_valid=0`, state IDLE.
- Reset mid-sweep aborts immediately and asynchronously. No partial results are retained.

## Timing

- Let E0 be the edge that samples `start`.
  - Vector 0 appears on `a_o`, `b_o`, `cin_o` after E0.
  - Vector k appears after E0 + k·(SETTLE+1).
- Each vector is held for exactly SETTLE+1 cycles: SETTLE cycles in WAIT and 1 in CHECK. The compare uses the values sampled at the edge ending CHECK.
- `done` rises, and `busy` falls, at E0 + 512·(SETTLE+1). For SETTLE=1 this is 1024 cycles after E0.
- `err_cnt` and `first_fail_*` update on the CHECK edge of the failing vector. They are stable once `done` is high.
- The adder path from `a_o`/`b_o`/`cin_o` to `sum_i`/`carry_i` must settle within SETTLE+1 cycles minus setup.

## Test plan

- Reset: assert `rst_n=0` with random inputs → all outputs at their reset values. Hold `start=0` for 20 cycles after release → `busy=0` and operands stay 0.
- Good adder, SETTLE=1: pulse `start` → `done=1` exactly 1024 cycles after E0, with `pass=1`, `err_cnt=0`, `first_fail_valid=0`. Operands step 0..511 as specified.
- Injected fault `sum[2]` stuck-at-0 → `err_cnt=256`, `first_fail_vec=4`, `pass=0`.
- Injected fault `carry` stuck-at-0 → `err_cnt=256`, `first_fail_vec=31` (a=15, b=1, cin=0).
- Pulse `start` again at cycle 500 of a sweep → ignored; `done` still arrives at cycle 1024. Then `start` from DONE → `done` clears the next cycle, the sweep restarts at v=0, and the counters are cleared.
- Drive `rst_n` low at cycle 300 of a faulty sweep → all outputs immediately return to reset values. After release and `start`, the sweep completes with the same counts as an uninterrupted run.
